// File: rtl/matrix_scan_if.sv
// Write port of the matrix frame store: row writes plus frame commit.
// Latency: n/a (signal bundle only).
// Backpressure: wr_ready low while a committed frame waits for its swap.
interface matrix_scan_if #(
  parameter int BIT_COUNT = 3,
  parameter int COL       = 8
);
  logic                 wr_valid;
  logic                 wr_ready;
  logic [BIT_COUNT-1:0] wr_row;
  logic [COL-1:0]       wr_data;
  logic                 commit;

  // game logic side
  modport master (
    output wr_valid, wr_row, wr_data, commit,
    input  wr_ready
  );

  // frame store side
  modport slave (
    input  wr_valid, wr_row, wr_data, commit,
    output wr_ready
  );
endinterface

// File: rtl/matrix_scan.sv
// 8x8 LED matrix row-scan controller with double-buffered frame store.
// Latency: write lands at accepting edge; commit shows at next frame wrap (1..ROW*SCAN_DIV cycles).
// Backpressure: wr_ready drops after commit and returns with swap_done; refused writes are dropped.
module matrix_scan #(
  parameter int ROW       = 8,
  parameter int COL       = 8,
  parameter int BIT_COUNT = 3,
  parameter int SCAN_DIV  = 1000,
  parameter int DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  matrix_scan_if.slave         wr,
  output logic [BIT_COUNT-1:0] count_row,
  output logic [ROW-1:0]       row_en,
  output logic [2*COL-1:0]     matrix_word,
  output logic                 frame_start,
  output logic                 swap_done
);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div;
  logic [COL-1:0]   back  [ROW];
  logic [COL-1:0]   front [ROW];
  logic             tick;
  logic             wrap;
  logic             pending;
  logic             wr_fire;
  logic             swap;
  logic [BIT_COUNT-1:0] idx_lo;
  logic [BIT_COUNT-1:0] idx_hi;

  assign pending     = (state_q == PENDING);
  assign wr.wr_ready = ~pending;
  assign wr_fire     = wr.wr_valid & ~pending;
  assign tick        = (div == DIV_W'(SCAN_DIV - 1));
  assign wrap        = tick && (count_row == BIT_COUNT'(ROW - 1));
  // swap only honours a commit registered before the wrapping tick
  assign swap        = wrap && pending;

  // commit state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // commit arms the swap; the wrapping tick performs it; extra commits are ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wr.commit) state_d = PENDING;
      PENDING: if (wrap)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // row prescaler and scan counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div       <= '0;
      count_row <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) count_row <= wrap ? '0 : count_row + 1'b1;
    end
  end

  // frame boundary and swap pulses, aligned with count_row returning to 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
      swap_done   <= 1'b0;
    end else begin
      frame_start <= wrap;
      swap_done   <= swap;
    end
  end

  // back buffer takes accepted writes; front copies back at the swap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ROW; i++) begin
        back[i]  <= '0;
        front[i] <= '0;
      end
    end else begin
      if (wr_fire) back[wr.wr_row] <= wr.wr_data;
      if (swap) begin
        for (int i = 0; i < ROW; i++) front[i] <= back[i];
      end
    end
  end

  // row drive and column word follow registered count_row directly
  always_comb begin
    idx_lo      = {count_row[BIT_COUNT-1:1], 1'b0};
    idx_hi      = {count_row[BIT_COUNT-1:1], 1'b1};
    row_en      = ROW'(1) << count_row;
    matrix_word = {front[idx_hi], front[idx_lo]};
  end

endmodule

// File: tb/tb_matrix_scan.sv
// Directed bench for matrix_scan with SCAN_DIV=4 (row period 4, frame period 32).
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: exercised by holding a write across a pending commit.
module tb_matrix_scan;

  localparam int ROW = 8, COL = 8, BIT_COUNT = 3, SCAN_DIV = 4, DIV_W = 16;

  logic                 clk;
  logic                 rst_n;
  logic [BIT_COUNT-1:0] count_row;
  logic [ROW-1:0]       row_en;
  logic [2*COL-1:0]     matrix_word;
  logic                 frame_start;
  logic                 swap_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int swaps  = 0;
  int exp_row;

  matrix_scan_if #(.BIT_COUNT(BIT_COUNT), .COL(COL)) wr_if ();

  matrix_scan #(
    .ROW(ROW), .COL(COL), .BIT_COUNT(BIT_COUNT), .SCAN_DIV(SCAN_DIV), .DIV_W(DIV_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr          (wr_if.slave),
    .count_row   (count_row),
    .row_en      (row_en),
    .matrix_word (matrix_word),
    .frame_start (frame_start),
    .swap_done   (swap_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one clock edge, then settle; cyc counts edges since the last reset release
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  initial begin
    // reset held 3 cycles with a write presented: must be dropped
    rst_n           = 1'b0;
    wr_if.wr_valid  = 1'b1;
    wr_if.wr_row    = 3'd0;
    wr_if.wr_data   = 8'hFF;
    wr_if.commit    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count_row", 32'(count_row), 32'd0);
    chk("rst_row_en", 32'(row_en), 32'h01);
    chk("rst_matrix_word", 32'(matrix_word), 32'h0000);
    chk("rst_wr_ready", 32'(wr_if.wr_ready), 32'd1);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_swap_done", 32'(swap_done), 32'd0);

    // release; commit immediately so the first wrap swaps the (all-zero) back buffer
    rst_n          = 1'b1;
    wr_if.wr_valid = 1'b0;
    wr_if.commit   = 1'b1;
    cyc            = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (cyc == 1) wr_if.commit = 1'b0;
      exp_row = (cyc / 4) % 8;
      chk("scan_count_row", 32'(count_row), 32'(exp_row));
      chk("scan_row_en", 32'(row_en), 32'(1) << exp_row);
      chk("scan_frame_start", 32'(frame_start), 32'(cyc == 32));
      chk("scan_swap_done", 32'(swap_done), 32'(cyc == 32));
      chk("scan_wr_ready", 32'(wr_if.wr_ready), 32'(cyc >= 32));
      chk("scan_matrix_word", 32'(matrix_word), 32'h0000);
    end

    // cyc 40: count_row=2; write row2=3C, row3=A5, then commit
    wr_if.wr_valid = 1'b1;
    wr_if.wr_row   = 3'd2;
    wr_if.wr_data  = 8'h3C;
    chk("wr_ready_before_write", 32'(wr_if.wr_ready), 32'd1);
    step();
    wr_if.wr_row  = 3'd3;
    wr_if.wr_data = 8'hA5;
    step();
    wr_if.wr_valid = 1'b0;
    wr_if.commit   = 1'b1;
    step();
    wr_if.commit = 1'b0;
    chk("pending_wr_ready", 32'(wr_if.wr_ready), 32'd0);
    chk("pending_no_swap", 32'(swap_done), 32'd0);

    // back-pressure: row2=FF held while pending must not land before the swap
    wr_if.wr_valid = 1'b1;
    wr_if.wr_row   = 3'd2;
    wr_if.wr_data  = 8'hFF;
    run_to(63);
    chk("bp_wr_ready", 32'(wr_if.wr_ready), 32'd0);
    chk("bp_count_row", 32'(count_row), 32'd7);
    chk("bp_swap_done", 32'(swap_done), 32'd0);
    step();  // cyc 64: wrap with swap
    chk("swap_swap_done", 32'(swap_done), 32'd1);
    chk("swap_frame_start", 32'(frame_start), 32'd1);
    chk("swap_wr_ready", 32'(wr_if.wr_ready), 32'd1);
    chk("swap_count_row", 32'(count_row), 32'd0);
    chk("swap_word_row0", 32'(matrix_word), 32'h0000);
    step();  // cyc 65: retried write accepted into back only
    wr_if.wr_valid = 1'b0;
    chk("swap_done_one_cycle", 32'(swap_done), 32'd0);
    chk("frame_start_one_cycle", 32'(frame_start), 32'd0);
    run_to(72);
    chk("show_row2", 32'(matrix_word), 32'hA53C);
    run_to(76);
    chk("show_row3", 32'(matrix_word), 32'hA53C);
    run_to(80);
    chk("show_row4", 32'(matrix_word), 32'h0000);

    // write and commit in the same cycle, then a second commit while pending
    wr_if.wr_valid = 1'b1;
    wr_if.wr_row   = 3'd4;
    wr_if.wr_data  = 8'h5A;
    wr_if.commit   = 1'b1;
    chk("simul_wr_ready", 32'(wr_if.wr_ready), 32'd1);
    step();
    wr_if.wr_valid = 1'b0;
    wr_if.commit   = 1'b0;
    chk("simul_pending", 32'(wr_if.wr_ready), 32'd0);
    step();
    wr_if.commit = 1'b1;
    step();
    wr_if.commit = 1'b0;
    swaps = 0;
    for (int k = 0; k < 47; k++) begin
      step();
      if (swap_done) swaps++;
      if (cyc == 104) chk("frame2_row2", 32'(matrix_word), 32'hA5FF);
      if (cyc == 112) chk("frame2_row4", 32'(matrix_word), 32'h005A);
    end
    chk("double_commit_swaps", 32'(swaps), 32'd1);

    // commit, then reset at count_row=5 while pending
    wr_if.commit = 1'b1;
    step();
    wr_if.commit = 1'b0;
    run_to(148);
    chk("pre_rst_count_row", 32'(count_row), 32'd5);
    chk("pre_rst_pending", 32'(wr_if.wr_ready), 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cyc   = 0;
    chk("midrst_count_row", 32'(count_row), 32'd0);
    chk("midrst_row_en", 32'(row_en), 32'h01);
    chk("midrst_matrix_word", 32'(matrix_word), 32'h0000);
    chk("midrst_wr_ready", 32'(wr_if.wr_ready), 32'd1);
    swaps = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (swap_done) swaps++;
      chk("post_rst_count_row", 32'(count_row), 32'((cyc / 4) % 8));
      chk("post_rst_frame_start", 32'(frame_start), 32'(cyc == 32));
      chk("post_rst_matrix_word", 32'(matrix_word), 32'h0000);
      chk("post_rst_wr_ready", 32'(wr_if.wr_ready), 32'd1);
    end
    chk("post_rst_swaps", 32'(swaps), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
